// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - word memory access controller: write, read and clear with ack timeout
module mem_access_ctrl #(
  parameter int                ADDR_W      = 25,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] CLEAR_LAST  = ADDR_W'(25'h1FFFFFF),
  parameter int                ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        modeIn,
  input  logic              ioDone,
  input  logic [ADDR_W-1:0] memoryAddress,
  input  logic [DATA_W-1:0] ioDataOut,
  output logic              memDone,
  output logic [DATA_W-1:0] readData,
  output logic              memErr,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRdata
);

  // The timer counts completed request cycles without ack; it never exceeds ACK_TIMEOUT-1.
  localparam int            TW         = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = (ACK_TIMEOUT < 1) ? '0 : TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CLEAR, DONE} state_t;

  state_t            state;
  logic              ioDonePrev;
  logic [ADDR_W-1:0] clearCnt;
  logic [TW-1:0]     ackTimer;
  logic              start;
  logic              timedOut;

  assign start    = ioDone & ~ioDonePrev;
  assign timedOut = (ackTimer == TIMER_LAST);

  // Single FSM: edge detect, operation capture, request handshake, clear stepping and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ioDonePrev <= 1'b0;
      memDone    <= 1'b1;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      readData   <= '0;
      memErr     <= 1'b0;
      clearCnt   <= '0;
      ackTimer   <= '0;
    end else begin
      ioDonePrev <= ioDone;
      case (state)
        IDLE: begin
          memDone <= 1'b1;
          // Mode 11 is a no-op: stay idle and leave memErr alone.
          if (start && modeIn != 2'b11) begin
            memErr   <= 1'b0;
            memDone  <= 1'b0;
            memReq   <= 1'b1;
            ackTimer <= '0;
            clearCnt <= '0;
            case (modeIn)
              2'b10: begin
                state    <= WRITE;
                memWe    <= 1'b1;
                memAddr  <= memoryAddress;
                memWdata <= ioDataOut;
              end
              2'b01: begin
                state   <= READ;
                memWe   <= 1'b0;
                memAddr <= memoryAddress;
              end
              default: begin
                state    <= CLEAR;
                memWe    <= 1'b1;
                memAddr  <= '0;
                memWdata <= '0;
              end
            endcase
          end
        end
        WRITE, READ: begin
          // An ack in the last allowed cycle wins over the timeout.
          if (memAck) begin
            memReq <= 1'b0;
            state  <= DONE;
            if (state == READ) readData <= memRdata;
          end else if (timedOut) begin
            memReq <= 1'b0;
            memErr <= 1'b1;
            state  <= DONE;
          end else begin
            ackTimer <= ackTimer + TW'(1);
          end
        end
        CLEAR: begin
          // memReq low here is the mandatory gap cycle between clear writes.
          if (!memReq) begin
            memReq   <= 1'b1;
            memAddr  <= clearCnt;
            ackTimer <= '0;
          end else if (memAck) begin
            memReq <= 1'b0;
            if (clearCnt == CLEAR_LAST) state <= DONE;
            else clearCnt <= clearCnt + ADDR_W'(1);
          end else if (timedOut) begin
            memReq <= 1'b0;
            memErr <= 1'b1;
            state  <= DONE;
          end else begin
            ackTimer <= ackTimer + TW'(1);
          end
        end
        DONE: begin
          memDone <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 25; width of the word address.
REQ-002 Parameter DATA_W, default 16; width of the data word.
REQ-003 Parameter CLEAR_LAST, default 25'h1FFFFFF; last address written by a clear operation, which starts at address 0.
REQ-004 Parameter ACK_TIMEOUT, default 255; the maximum number of cycles to wait for memAck per transaction.
REQ-005 clk  in  1  sole clock; all logic SHALL be clocked on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 modeIn  in  2  operation select: 00 clear, 01 read, 10 write, 11 none.
REQ-008 ioDone  in  1  level request from the upstream input/output controller; a rising edge SHALL start an operation.
REQ-009 memoryAddress  in  ADDR_W  target word address for read and write.
REQ-010 ioDataOut  in  DATA_W  write data.
REQ-011 memDone  out  1  high = idle and ready; low = operation in progress.
REQ-012 readData  out  DATA_W  last word read; drives the hex display path.
REQ-013 memErr  out  1  sticky flag set on an acknowledge timeout.
REQ-014 memReq  out  1  external memory request.
REQ-015 memWe  out  1  1 = write, 0 = read; valid while memReq=1.
REQ-016 memAddr  out  ADDR_W  external address; valid while memReq=1.
REQ-017 memWdata  out  DATA_W  external write data; valid while memReq=1 and memWe=1.
REQ-018 memAck  in  1  one-cycle acknowledge from memory; read data is valid in the same cycle.
REQ-019 memRdata  in  DATA_W  external read data.

Function
REQ-020 The block SHALL register ioDone and detect a start as ioDone=1 with the previous ioDone=0; a level held high SHALL NOT retrigger.
REQ-021 The FSM SHALL have the states IDLE, WRITE, READ, CLEAR and DONE.
REQ-022 IDLE transitions on start:
- modeIn=10 -> WRITE
- modeIn=01 -> READ
- modeIn=00 -> CLEAR
- modeIn=11 -> remain in IDLE; no memory activity.
REQ-023 On start, the block SHALL capture memoryAddress, ioDataOut and modeIn into internal registers; later input changes SHALL NOT affect the operation in progress.
REQ-024 memDone SHALL be 1 only in IDLE; it SHALL fall the cycle after start is sampled.
REQ-025 Handshake: memReq, memWe, memAddr and memWdata SHALL be held stable from assertion until the cycle memAck=1 is sampled.
REQ-026 memReq SHALL drop in the cycle following the sampled ack.
REQ-027 memAck received while memReq=0 SHALL be ignored.
REQ-028 WRITE: issue one request with memWe=1 at the captured address and data; on ack -> DONE.
REQ-029 READ: issue one request with memWe=0; on ack, load memRdata into readData and go to DONE.
REQ-030 readData SHALL otherwise hold its value.
REQ-031 CLEAR: an address counter starts at 0; write data is all zeros with memWe=1.
REQ-032 CLEAR stepping: after each ack, increment the counter; re-assert memReq the following cycle; after the ack at CLEAR_LAST -> DONE.
REQ-033 CLEAR_LAST=0 SHALL produce exactly one write.
REQ-034 The counter SHALL NOT wrap.
REQ-035 Minimum spacing between consecutive requests: one cycle with memReq=0.
REQ-036 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-037 Timeout: a per-transaction counter starts at request assertion.
REQ-038 If ACK_TIMEOUT cycles elapse without ack: drop memReq, set memErr, go to DONE, and abandon the remainder of a CLEAR.
REQ-039 A timed-out read SHALL NOT update readData.
REQ-040 memErr SHALL clear only on reset or on the next accepted start.
REQ-041 A start edge occurring while not in IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-042 When rst=1 at a clock edge, the next state SHALL be IDLE, with:
- memDone=1
- memReq=0, memWe=0
- memAddr=0, memWdata=0
- readData=0
- memErr=0
- all counters 0
- the registered ioDone = 0.
REQ-043 Reset asserted mid-transaction SHALL drop memReq the next cycle and abandon the operation.
REQ-044 After reset deasserts, ioDone already high SHALL be treated as a rising edge.

Verification
REQ-045 Write: modeIn=10, memoryAddress=0x0001234, ioDataOut=0xBEEF, ioDone rising; ack after 3 cycles -> memReq=1 with memWe=1, addr 0x0001234 and data 0xBEEF held stable; memDone low, then high 2 cycles after the ack.
REQ-046 Read: modeIn=01, address 0x1000005; memRdata=0xA5A5 with ack -> readData=0xA5A5; memWe=0 throughout.
REQ-047 Clear with CLEAR_LAST=3, immediate acks -> exactly 4 writes of 0x0000 to addresses 0,1,2,3 with gaps, then memDone=1.
REQ-048 Timeout with ACK_TIMEOUT=4 and no ack -> memReq drops after 4 cycles; memErr=1; readData unchanged; the next start clears memErr.
REQ-049 Held ioDone and mode 11: ioDone held high for 20 cycles -> exactly one operation; a rising edge with modeIn=11 -> no memReq and memDone stays 1.
REQ-050 Reset and ignored start:
- rst asserted during the 2nd CLEAR write -> memReq=0 the next cycle and all outputs at reset values.
- a start during WRITE -> ignored.
